// File: rtl/sdram_addr_gen.sv
// Multi-channel SDRAM address generator: one wrapping burst pointer per channel,
// each confined to a programmable [base, limit] region.

module sdram_addr_ch #(
    parameter int ADDR_W = 26,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_limit,
    input  logic              sel,
    input  logic              enable,
    input  logic              rewind,
    input  logic [STEP_W-1:0] step,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap_hit,
    output logic              region_done
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W:0]   sum;
    logic              adv;
    logic              over;

    // The extra sum bit catches a step carrying past the top of the address space.
    always_comb begin
        sum      = {1'b0, ptr} + {{(ADDR_W+1-STEP_W){1'b0}}, step};
        over     = sum > {1'b0, limit};
        adv      = sel && enable && (step != '0) && !rewind && !ld;
        wrap_hit = adv && over;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base        <= '0;
            limit       <= '1;
            ptr         <= '0;
            region_done <= 1'b0;
        end else if (ld) begin
            base        <= ld_base;
            limit       <= ld_limit;
            ptr         <= ld_base;
            region_done <= 1'b0;
        end else if (sel && rewind) begin
            ptr <= base;
        end else if (adv) begin
            if (over) begin
                ptr         <= base;
                region_done <= 1'b1;
            end else begin
                ptr <= sum[ADDR_W-1:0];
            end
        end
    end

endmodule

module sdram_addr_gen #(
    parameter int ADDR_W = 26,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cfg_load,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_limit,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              enable,
    input  logic [STEP_W-1:0] step,
    input  logic              rewind,
    output logic [ADDR_W-1:0] sdram_address,
    output logic              wrap,
    output logic [NUM_CH-1:0] region_done,
    output logic              cfg_err
);

    logic                           cfg_ok;
    logic [NUM_CH-1:0]              ld;
    logic [NUM_CH-1:0]              sel;
    logic [NUM_CH-1:0]              wrap_hit;
    logic [NUM_CH-1:0][ADDR_W-1:0]  ptr;

    assign cfg_ok = cfg_load && (cfg_base <= cfg_limit);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ld[i]  = cfg_ok && (cfg_ch == CH_W'(i));
        assign sel[i] = (ch_sel == CH_W'(i));

        sdram_addr_ch #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) u_ch (
            .clk         (clk),
            .n_rst       (n_rst),
            .ld          (ld[i]),
            .ld_base     (cfg_base),
            .ld_limit    (cfg_limit),
            .sel         (sel[i]),
            .enable      (enable),
            .rewind      (rewind),
            .step        (step),
            .ptr         (ptr[i]),
            .wrap_hit    (wrap_hit[i]),
            .region_done (region_done[i])
        );
    end

    // Zero-latency output mux; an out-of-range ch_sel reads 0.
    always_comb begin
        sdram_address = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (sel[i]) sdram_address = ptr[i];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wrap    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            wrap    <= |wrap_hit;
            cfg_err <= cfg_load && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_sdram_addr_gen.sv
// Directed and randomized checks of sdram_addr_gen against a behavioural region model.

module tb_sdram_addr_gen;

    localparam int ADDR_W = 26;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int STEP_W = 4;
    localparam longint TOP = (64'd1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              cfg_load;
    logic [CH_W-1:0]   cfg_ch;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_limit;
    logic [CH_W-1:0]   ch_sel;
    logic              enable;
    logic [STEP_W-1:0] step;
    logic              rewind;
    logic [ADDR_W-1:0] sdram_address;
    logic              wrap;
    logic [NUM_CH-1:0] region_done;
    logic              cfg_err;

    sdram_addr_gen #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .STEP_W(STEP_W)) dut (
        .clk(clk), .n_rst(n_rst), .cfg_load(cfg_load), .cfg_ch(cfg_ch),
        .cfg_base(cfg_base), .cfg_limit(cfg_limit), .ch_sel(ch_sel),
        .enable(enable), .step(step), .rewind(rewind),
        .sdram_address(sdram_address), .wrap(wrap),
        .region_done(region_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint m_base [NUM_CH];
    longint m_limit[NUM_CH];
    longint m_ptr  [NUM_CH];
    logic [NUM_CH-1:0] m_done;
    logic m_wrap, m_err;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_base[i] = 0; m_limit[i] = TOP; m_ptr[i] = 0;
        end
        m_done = '0; m_wrap = 0; m_err = 0;
    endtask

    task automatic idle_inputs();
        cfg_load = 0; cfg_ch = 0; cfg_base = 0; cfg_limit = 0;
        enable = 0; step = 0; rewind = 0;
    endtask

    // Inputs are already driven; check the mux, step the model, clock, check outputs.
    task automatic cyc();
        int s;
        bit loaded_sel;
        longint sum;
        #1 chk("addr_pre", sdram_address, m_ptr[int'(ch_sel)]);
        s = int'(ch_sel);
        m_wrap = 0; m_err = 0; loaded_sel = 0;
        if (cfg_load) begin
            if (longint'(cfg_base) <= longint'(cfg_limit)) begin
                m_base[cfg_ch] = cfg_base; m_limit[cfg_ch] = cfg_limit;
                m_ptr[cfg_ch] = cfg_base; m_done[cfg_ch] = 0;
                loaded_sel = (cfg_ch == ch_sel);
            end else m_err = 1;
        end
        if (!loaded_sel) begin
            if (rewind) m_ptr[s] = m_base[s];
            else if (enable && step != 0) begin
                sum = m_ptr[s] + longint'(step);
                if (sum > m_limit[s]) begin
                    m_ptr[s] = m_base[s]; m_done[s] = 1; m_wrap = 1;
                end else m_ptr[s] = sum;
            end
        end
        @(posedge clk); #1;
        chk("wrap", wrap, m_wrap);
        chk("cfg_err", cfg_err, m_err);
        chk("region_done", region_done, m_done);
        chk("addr_post", sdram_address, m_ptr[int'(ch_sel)]);
        idle_inputs();
    endtask

    task automatic load(input int ch, input longint b, input longint l);
        cfg_load = 1; cfg_ch = CH_W'(ch); cfg_base = ADDR_W'(b); cfg_limit = ADDR_W'(l);
        cyc();
    endtask

    task automatic adv(input int ch, input int st);
        ch_sel = CH_W'(ch); enable = 1; step = STEP_W'(st);
        cyc();
    endtask

    initial begin
        n_rst = 0; ch_sel = 0; idle_inputs(); model_reset();
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel = CH_W'(i); #1;
            chk("rst_addr", sdram_address, 0);
        end
        chk("rst_done", region_done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", cfg_err, 0);
        n_rst = 1;
        @(posedge clk); #1;

        // Region walk and wrap on ch0, ch1 untouched
        load(0, 300, 315);
        load(1, 3000, 3999);
        ch_sel = 0; #1 chk("t2_start", sdram_address, 300);
        adv(0, 4); chk("t2_a1", sdram_address, 304);
        adv(0, 4); chk("t2_a2", sdram_address, 308);
        adv(0, 4); chk("t2_a3", sdram_address, 312);
        adv(0, 4); chk("t2_wrap_addr", sdram_address, 300);
        chk("t2_wrap", wrap, 1);
        chk("t2_done0", region_done[0], 1);
        cyc(); chk("t2_wrap_clr", wrap, 0);
        ch_sel = 1; #1 chk("t2_ch1", sdram_address, 3000);

        // Exact-limit wrap, zero step, rewind beating enable
        load(2, 10, 12);
        adv(2, 1); adv(2, 1); chk("t3_at_lim", sdram_address, 12);
        adv(2, 1); chk("t3_wrap", sdram_address, 10); chk("t3_wrap_p", wrap, 1);
        adv(2, 0); chk("t3_hold", sdram_address, 10); chk("t3_nowrap", wrap, 0);
        adv(2, 1); chk("t3_11", sdram_address, 11);
        ch_sel = 2; rewind = 1; enable = 1; step = 1; cyc();
        chk("t3_rewind", sdram_address, 10); chk("t3_rw_nowrap", wrap, 0);

        // Rejected then accepted config
        load(3, 500, 400); chk("t4_err", cfg_err, 1);
        cyc(); chk("t4_err_clr", cfg_err, 0);
        load(0, 50, 60); ch_sel = 0; #1 chk("t4_ptr0", sdram_address, 50);
        chk("t4_done_clr", region_done[0], 0);

        // Same-cycle load/advance interactions
        ch_sel = 1; enable = 1; step = 8;
        cfg_load = 1; cfg_ch = 1; cfg_base = 2000; cfg_limit = 2100; cyc();
        chk("t5_load_wins", sdram_address, 2000);
        ch_sel = 0; enable = 1; step = 3;
        cfg_load = 1; cfg_ch = 2; cfg_base = 700; cfg_limit = 800; cyc();
        chk("t5_ch0_adv", sdram_address, 53);
        ch_sel = 2; #1 chk("t5_ch2_load", sdram_address, 700);

        // Top-of-space wrap goes to base, not 0
        load(3, TOP - 15, TOP);
        adv(3, 8); chk("t6_pre", sdram_address, TOP - 7);
        adv(3, 15); chk("t6_wrap", sdram_address, TOP - 15); chk("t6_wrap_p", wrap, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ch_sel = CH_W'($urandom_range(0, NUM_CH - 1));
            enable = ($urandom_range(0, 1) == 1);
            step   = STEP_W'($urandom);
            rewind = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                longint b;
                b = ($urandom_range(0, 3) == 0) ? TOP - longint'($urandom_range(0, 40))
                                                : longint'($urandom_range(0, 5000));
                cfg_load = 1; cfg_ch = CH_W'($urandom_range(0, NUM_CH - 1));
                cfg_base = ADDR_W'(b);
                cfg_limit = ($urandom_range(0, 4) == 0) ? ADDR_W'(b - 1)
                          : ADDR_W'((b + longint'($urandom_range(0, 60)) > TOP) ? TOP
                                    : b + longint'($urandom_range(0, 60)));
            end
            cyc();
        end

        // Async reset mid-operation, right after a wrap pulse
        load(0, 100, 101);
        adv(0, 1);
        adv(0, 1); chk("t7_wrap", wrap, 1);
        n_rst = 0; #1;
        model_reset();
        chk("t7_addr", sdram_address, 0);
        chk("t7_wrap_rst", wrap, 0);
        chk("t7_done_rst", region_done, 0);
        chk("t7_err_rst", cfg_err, 0);
        @(posedge clk); #2 n_rst = 1;
        @(posedge clk); #1;
        adv(0, 5); chk("t7_post", sdram_address, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
